tan_share_arbiter: RTL and testbench
====================================

# tan_share_arbiter

Round-robin controller that shares one tangent datapath (16-bit unsigned Q0.16 operand in, Q0.16 result out, start/busy/ready handshake) among N requesters. It latches the winning requester's operand, sequences the start/busy/ready handshake, watches for a hung unit with a timeout, and returns the result to the winner with a one-cycle acknowledge. It sits between the requesting units and the tangent unit, and is the only driver of that unit's start and operand inputs.

## Interface
- N, 4, number of requesters (2..8)
- W, 16, operand/result width (Q0.16)
- TIMEOUT, 1024, max cycles from launch to result before abort
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- req  in  N  req[i] level request; held high until ack[i]
- req_x  in  N*W  operand of requester i in bits [i*W +: W]; stable while req[i] high
- ack  out  N  one-hot, one-cycle pulse: result for requester i valid
- err  out  1  pulses with ack when the operation timed out
- res_y  out  W  result, valid while ack high (0 on timeout)
- grant_id  out  $clog2(N)  index of the requester being served
- ctl_busy  out  1  high in every state except IDLE
- tan_start  out  1  start to the tangent unit
- tan_x  out  W  operand to the tangent unit
- tan_busy  in  1  unit busy
- tan_ready  in  1  unit result valid (may stay high between operations)
- tan_y  in  W  unit result

## Operation
- States: IDLE, START, RUN, DONE. All outputs are registered.
- Reset (async, any state): state=IDLE; ack=0, err=0, res_y=0, grant_id=0, ctl_busy=0, tan_start=0, tan_x=0; last_grant=N-1, so requester 0 has first priority. A reset during an operation drops tan_start at once and delivers no ack.
- IDLE: when req != 0, grant the first set bit searching from last_grant+1 with wrap-around. Latch grant_id, tan_x <= req_x[grant], clear the timeout counter, and go to START. req is sampled only in IDLE.
- START: tan_start=1. When tan_busy=1, go to RUN with tan_start=0.
- RUN: when tan_busy=0 && tan_ready=1, set res_y <= tan_y, ack[grant_id]=1, err=0, last_grant <= grant_id, and go to DONE. A stale tan_ready from the previous operation is ignored, because RUN is only entered after busy has been seen high.
- Timeout: the counter increments each cycle in START and RUN. When it reaches TIMEOUT-1, go to DONE with res_y=0, err=1, ack[grant_id]=1, tan_start=0. last_grant still advances.
- DONE: lasts one cycle, with ack and err high. Then go to IDLE with ack=0 and err=0.
- Requester contract: clear req[i] on the clock edge where ack[i]=1. Its next request is then eligible on the following IDLE cycle, behind the other pending requesters.
- Simultaneous requests: exactly one grant per operation. No requester waits more than N-1 operations.
- req[i] dropping before ack is a protocol violation. The operation completes and ack is still pulsed.

## Timing
- Request seen in IDLE at edge c: tan_start and tan_x are valid from c+1.
- tan_start stays high until the edge after tan_busy is first sampled high.
- Result seen at edge r: ack, res_y and err are valid in cycle r+1 (DONE), and the state is IDLE at r+2.
- Minimum turnaround between grants: 1 IDLE cycle after DONE.
- Total latency per request = 1 (IDLE) + START cycles + unit latency + 1 (DONE).
- The counter width is $clog2(TIMEOUT). It is not reset by busy or ready activity.

## Test plan
- Single request: bench unit model returns y = x ^ 16'hA5A5 after 20 busy cycles. req[2]=1, x=16'h6488 -> ack=4'b0100, res_y=16'hC12D, err=0, grant_id=2.
- Contention: req=4'b1111 with distinct x values from reset -> acks in order 0,1,2,3. Each result matches its own operand; no two acks overlap.
- Fairness: requester 1 re-requests immediately after each ack while req[3] is held -> grants alternate 1,3,1,3.
- Stale ready: model holds tan_ready=1 while idle and asserts busy 3 cycles after start, x=16'hC90F -> ack only after the busy falling edge, res_y=16'h6CAA.
- Timeout: model never asserts busy, TIMEOUT=1024 -> ack and err pulse together exactly 1024 cycles after tan_start rises, res_y=0, then the next requester is served.
- Reset mid-RUN: rst pulsed 10 cycles into RUN -> all outputs are 0 at once, no ack, and requester 0 wins first after release.

Source files
------------

// File: rtl/tan_share_arbiter.sv
// tan_share_arbiter: round-robin front end that shares one tangent unit
// among N requesters. It latches the winner's operand, runs the
// start/busy/ready handshake, aborts a hung operation after TIMEOUT
// cycles and hands the result back with a one-cycle one-hot ack.
module tan_share_arbiter #(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       req_x,
  output logic [N-1:0]         ack,
  output logic                 err,
  output logic [W-1:0]         res_y,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 ctl_busy,
  output logic                 tan_start,
  output logic [W-1:0]         tan_x,
  input  logic                 tan_busy,
  input  logic                 tan_ready,
  input  logic [W-1:0]         tan_y
);

  localparam int GW = $clog2(N);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_RST = GW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          err_q, err_d;
  logic [W-1:0]  res_y_q, res_y_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic          ctl_busy_q, ctl_busy_d;
  logic          tan_start_q, tan_start_d;
  logic [W-1:0]  tan_x_q, tan_x_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Round-robin pick: first pending request after last_grant, wrapping.
  // The sum is one bit wider so non-power-of-two N wraps correctly.
  logic [GW-1:0] pick;
  logic          pick_vld;
  logic [GW:0]   sum;
  logic [GW-1:0] idx;
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, last_grant_q} + (GW+1)'(k);
      if (sum >= (GW+1)'(N)) sum = sum - (GW+1)'(N);
      idx = sum[GW-1:0];
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Operand mux for the picked requester.
  logic [W-1:0] pick_x;
  always_comb begin
    pick_x = '0;
    for (int i = 0; i < N; i++) begin
      if (pick == GW'(i)) pick_x = req_x[i*W +: W];
    end
  end

  // Next-state and registered-output logic for the handshake sequencer.
  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    err_d        = 1'b0;
    res_y_d      = res_y_q;
    grant_id_d   = grant_id_q;
    tan_start_d  = tan_start_q;
    tan_x_d      = tan_x_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_id_d  = pick;
          tan_x_d     = pick_x;
          cnt_d       = '0;
          tan_start_d = 1'b1;
          state_d     = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_MAX) begin
          // Unit never acknowledged the start: abort with err.
          state_d             = S_DONE;
          res_y_d             = '0;
          err_d               = 1'b1;
          ack_d[grant_id_q]   = 1'b1;
          tan_start_d         = 1'b0;
          last_grant_d        = grant_id_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (tan_busy) begin
            tan_start_d = 1'b0;
            state_d     = S_RUN;
          end
        end
      end

      S_RUN: begin
        // Busy was already seen high, so any ready here belongs to this op.
        if (!tan_busy && tan_ready) begin
          state_d           = S_DONE;
          res_y_d           = tan_y;
          ack_d[grant_id_q] = 1'b1;
          last_grant_d      = grant_id_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d           = S_DONE;
          res_y_d           = '0;
          err_d             = 1'b1;
          ack_d[grant_id_q] = 1'b1;
          tan_start_d       = 1'b0;
          last_grant_d      = grant_id_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        tan_start_d = 1'b0;
      end
    endcase

    ctl_busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ack_q        <= '0;
      err_q        <= 1'b0;
      res_y_q      <= '0;
      grant_id_q   <= '0;
      ctl_busy_q   <= 1'b0;
      tan_start_q  <= 1'b0;
      tan_x_q      <= '0;
      last_grant_q <= LAST_RST;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      res_y_q      <= res_y_d;
      grant_id_q   <= grant_id_d;
      ctl_busy_q   <= ctl_busy_d;
      tan_start_q  <= tan_start_d;
      tan_x_q      <= tan_x_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign res_y     = res_y_q;
  assign grant_id  = grant_id_q;
  assign ctl_busy  = ctl_busy_q;
  assign tan_start = tan_start_q;
  assign tan_x     = tan_x_q;

endmodule

// File: tb/tb_tan_share_arbiter.sv
// Bench for tan_share_arbiter: a behavioural tangent-unit model
// (y = x ^ A5A5 after 20 busy cycles) plus directed and random requests
// checked against a round-robin reference model.
module tb_tan_share_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_x;
  logic [W-1:0]   xs [N];
  logic [N-1:0]   ack;
  logic           err;
  logic [W-1:0]   res_y;
  logic [1:0]     grant_id;
  logic           ctl_busy, tan_start;
  logic [W-1:0]   tan_x;
  logic           tan_busy, tan_ready;
  logic [W-1:0]   tan_y;

  int tests = 0;
  int fails = 0;
  logic [1:0] last;

  // unit model knobs
  int start_dly = 1;
  bit hang = 1'b0;
  bit m_run;
  int m_dly, m_cnt;
  logic [W-1:0] m_x;

  tan_share_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .ack(ack), .err(err),
    .res_y(res_y), .grant_id(grant_id), .ctl_busy(ctl_busy),
    .tan_start(tan_start), .tan_x(tan_x), .tan_busy(tan_busy),
    .tan_ready(tan_ready), .tan_y(tan_y)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_x[i*W +: W] = xs[i];
  end

  // tangent unit model: busy start_dly cycles after start, 20 busy cycles,
  // ready stays high until the next operation begins
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tan_busy <= 1'b0; tan_ready <= 1'b0; tan_y <= '0;
      m_run <= 1'b0; m_dly <= 0; m_cnt <= 0; m_x <= '0;
    end else if (!m_run) begin
      if (tan_start && !hang) begin
        if (m_dly + 1 >= start_dly) begin
          tan_busy <= 1'b1; tan_ready <= 1'b0; m_x <= tan_x;
          m_cnt <= 0; m_dly <= 0; m_run <= 1'b1;
        end else begin
          m_dly <= m_dly + 1;
        end
      end
    end else begin
      if (m_cnt == 19) begin
        tan_busy <= 1'b0; tan_ready <= 1'b1; tan_y <= m_x ^ 16'hA5A5; m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference arbitration: first pending index after the previous winner
  function automatic logic [1:0] rr_pick(input logic [N-1:0] pend, input logic [1:0] prev);
    logic [1:0] j;
    for (int k = 1; k <= N; k++) begin
      j = prev + 2'(k);
      if (pend[j]) return j;
    end
    return prev;
  endfunction

  task automatic wait_ack(output logic [1:0] idx, output logic [W-1:0] y,
                          output logic e, output int cyc, output bit ok);
    cyc = 0; ok = 1'b0; idx = '0; y = '0; e = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack == '0 && cyc < 3000);
    if (ack != '0) begin
      ok = 1'b1; y = res_y; e = err;
      for (int i = 0; i < N; i++) if (ack[i]) idx = 2'(i);
      check("ack_onehot", $countones(ack), 1);
      req[idx] = 1'b0;
    end
  endtask

  task automatic serve(input string tag, output logic [1:0] got);
    logic [1:0] exp;
    logic [W-1:0] xv, y;
    logic e;
    int cyc;
    bit ok;
    exp = rr_pick(req, last);
    xv = xs[exp];
    wait_ack(got, y, e, cyc, ok);
    check({tag, "_seen"}, 32'(ok), 1);
    check({tag, "_idx"}, 32'(got), 32'(exp));
    check({tag, "_res"}, 32'(y), 32'(xv ^ 16'hA5A5));
    check({tag, "_err"}, 32'(e), 0);
    last = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] got;
    logic [1:0] exp;
    logic [W-1:0] y;
    logic e;
    int cyc;
    bit ok;

    rst = 1'b1; req = '0; last = 2'd3;
    for (int i = 0; i < N; i++) xs[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_res", 32'(res_y), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_busy", 32'(ctl_busy), 0);
    check("rst_start", 32'(tan_start), 0);
    check("rst_tanx", 32'(tan_x), 0);
    rst = 1'b0;
    @(negedge clk);

    // single request
    xs[2] = 16'h6488; req[2] = 1'b1;
    @(negedge clk);
    check("single_start", 32'(tan_start), 1);
    check("single_tanx", 32'(tan_x), 32'h6488);
    check("single_gid", 32'(grant_id), 2);
    check("single_busy", 32'(ctl_busy), 1);
    serve("single", got);
    check("single_val", 32'(res_y), 32'hC12D);
    @(negedge clk);
    check("single_ack_pulse", 32'(ack), 0);
    check("single_idle", 32'(ctl_busy), 0);

    // stale ready: ready still high from previous op, busy arrives late
    start_dly = 3;
    xs[1] = 16'hC90F; req[1] = 1'b1;
    serve("stale", got);
    check("stale_val", 32'(res_y), 32'h6CAA);
    start_dly = 1;
    @(negedge clk);

    // contention from reset
    rst = 1'b1; @(negedge clk); rst = 1'b0; last = 2'd3;
    for (int i = 0; i < N; i++) xs[i] = {2'(i), 14'($urandom)};
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      serve("cont", got);
      check("cont_order", 32'(got), i);
    end

    // fairness: 1 re-requests at once while 3 is held
    xs[1] = 16'($urandom); xs[3] = 16'($urandom);
    req[1] = 1'b1; req[3] = 1'b1;
    for (int it = 0; it < 4; it++) begin
      serve("fair", got);
      check("fair_seq", 32'(got), (it % 2 == 1) ? 3 : 1);
      if (it < 2) begin
        xs[got] = 16'($urandom);
        req[got] = 1'b1;
      end
    end

    // random traffic vs reference model
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          xs[i] = 16'($urandom); req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        xs[0] = 16'($urandom); req[0] = 1'b1;
      end
      start_dly = $urandom_range(1, 4);
      serve("rand", got);
    end
    while (req != '0) serve("drain", got);
    start_dly = 1;

    // timeout: unit hangs, next requester then served normally
    hang = 1'b1;
    xs[0] = 16'($urandom); xs[1] = 16'($urandom);
    req = 4'b0011;
    exp = rr_pick(req, last);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!tan_start && cyc < 20);
    check("to_start_seen", 32'(tan_start), 1);
    wait_ack(got, y, e, cyc, ok);
    check("to_seen", 32'(ok), 1);
    check("to_cycles", 32'(cyc), TIMEOUT);
    check("to_idx", 32'(got), 32'(exp));
    check("to_err", 32'(e), 1);
    check("to_res", 32'(y), 0);
    last = exp;
    hang = 1'b0;
    serve("after_to", got);
    check("after_to_idx", 32'(got), 32'(~exp[0] ? 1 : 0));

    // reset 10 cycles into RUN
    @(negedge clk);
    xs[2] = 16'h1234; req[2] = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(tan_busy && !tan_start) && cyc < 50);
    check("mr_run_reached", 32'(tan_busy && !tan_start), 1);
    repeat (10) @(negedge clk);
    check("mr_busy_before", 32'(ctl_busy), 1);
    rst = 1'b1;
    #1;
    check("mr_ack", 32'(ack), 0);
    check("mr_err", 32'(err), 0);
    check("mr_res", 32'(res_y), 0);
    check("mr_gid", 32'(grant_id), 0);
    check("mr_busy", 32'(ctl_busy), 0);
    check("mr_start", 32'(tan_start), 0);
    check("mr_tanx", 32'(tan_x), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_no_ack", 32'(ack), 0);
    end
    rst = 1'b0; last = 2'd3;
    xs[0] = 16'($urandom); xs[3] = 16'($urandom);
    req[0] = 1'b1; req[3] = 1'b1;
    serve("post_rst", got);
    check("post_rst_first", 32'(got), 0);
    while (req != '0) serve("post_rst_drain", got);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
